// File: rtl/ring_osc_cal_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ring_cal_pkg
//
// Shared definitions for the ring oscillator calibration controller:
//   - cal_state_e    : sequencer states
//   - DEF_*          : default parameter values used by the top level
//   - SEL_MAX        : highest tap index for the default select width
//   - sel_max()      : highest tap index for an arbitrary select width
// ---------------------------------------------------------------------------
package ring_cal_pkg;

    // Sequencer states. IDLE must stay at encoding 0 so that reset and the
    // enum default agree.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        EVAL    = 3'd3,
        DONE    = 3'd4
    } cal_state_e;

    // Default parameter values
    localparam int DEF_SEL_W      = 3;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_WINDOW_CYC = 1024;

    // Longest (slowest) tap for the default select width
    localparam int SEL_MAX = (1 << DEF_SEL_W) - 1;

    // Longest (slowest) tap for any select width
    function automatic int sel_max(input int sel_w);
        return (1 << sel_w) - 1;
    endfunction

endpackage

// File: rtl/ring_osc_cal_ctrl_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//
// Brings an asynchronous input into the clk domain through a two-flop
// synchronizer, then compares the synchronized value with its previous
// sample to produce a one-clock pulse on every rising edge.
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   async_in   in   signal asynchronous to clk
//   edge_pulse out  one-clk pulse when the synchronized input goes 0 -> 1
//
// The input must toggle slower than clk/4 so that every high and low phase
// spans at least two samples; faster inputs lose edges.
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state for the synchronizer chain and the previous-sample stage.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and history flops; all clear to 0 on reset so that a ring
    // that is already high at reset release does not create a phantom edge
    // until it has actually passed through the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Rising edge: synchronized value high while the previous sample was low.
    assign edge_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/ring_osc_cal_ctrl.sv
// ---------------------------------------------------------------------------
// ring_osc_cal_ctrl
//
// Calibration sequencer for a tapped inverter-chain ring oscillator. On
// start it enables the ring and walks stage_sel from the shortest (fastest)
// tap to the longest. At each tap it waits SETTLE_CYC cycles, counts ring
// rising edges over WINDOW_CYC cycles, and stops at the first tap whose
// count is at or below the target latched at start.
//
// Parameters:
//   SEL_W       width of stage_sel
//   CNT_W       width of target, count and the edge counter
//   SETTLE_CYC  cycles waited after a tap change (>= 1)
//   WINDOW_CYC  cycles in a measurement window (>= 1)
//
// Ports:
//   clk        in   system clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin calibration; only honoured in IDLE
//   abort      in   cancel calibration from any state; wins over start
//   target     in   maximum acceptable edges per window; latched at start
//   ring_in    in   ring oscillator output, asynchronous to clk
//   ring_en    out  ring enable
//   stage_sel  out  ring tap select
//   busy       out  high in SETTLE, MEASURE and EVAL
//   done       out  one-cycle completion pulse (DONE state)
//   locked     out  last calibration met its target
//   count      out  edge count of the most recent window
//
// Timing: one tap costs SETTLE_CYC + WINDOW_CYC + 1 cycles. With start
// sampled at edge N and a lock at tap k, done is high in the cycle after
// edge N + (k+1)*(SETTLE_CYC+WINDOW_CYC+1).
// ---------------------------------------------------------------------------
module ring_osc_cal_ctrl
    import ring_cal_pkg::*;
#(
    parameter int SEL_W      = DEF_SEL_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target,
    input  logic             ring_in,
    output logic             ring_en,
    output logic [SEL_W-1:0] stage_sel,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic [CNT_W-1:0] count
);

    // One shared phase counter serves both SETTLE and MEASURE, so it is sized
    // for the longer of the two intervals.
    localparam int MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(sel_max(SEL_W));
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    cal_state_e       state_q,    state_d;
    logic [CYC_W-1:0] cyc_cnt_q,  cyc_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] target_q,   target_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic             locked_q,   locked_d;
    logic             ring_en_q,  ring_en_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic             ring_edge;

    // Synchronize the ring and turn each rising edge into a single pulse.
    sync_edge_det u_sync_edge_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (ring_in),
        .edge_pulse (ring_edge)
    );

    // Next-state and datapath logic. abort is checked first so it overrides
    // both a simultaneous start and any in-progress step. Because ring_en is
    // cleared on a failed sweep and on abort, and left set on a lock, it
    // equals locked whenever the sequencer is back in IDLE.
    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        edge_cnt_d = edge_cnt_q;
        target_d   = target_q;
        sel_d      = sel_q;
        locked_d   = locked_q;
        ring_en_d  = ring_en_q;
        count_d    = count_q;

        if (abort) begin
            state_d   = IDLE;
            ring_en_d = 1'b0;
            locked_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        target_d  = target;
                        sel_d     = '0;
                        locked_d  = 1'b0;
                        ring_en_d = 1'b1;
                        cyc_cnt_d = '0;
                        state_d   = SETTLE;
                    end
                end

                SETTLE: begin
                    if (cyc_cnt_q == SETTLE_LAST) begin
                        cyc_cnt_d  = '0;
                        edge_cnt_d = '0;
                        state_d    = MEASURE;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
                    end
                end

                MEASURE: begin
                    if (ring_edge && (edge_cnt_q != CNT_SAT)) begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                    if (cyc_cnt_q == WINDOW_LAST) begin
                        cyc_cnt_d = '0;
                        state_d   = EVAL;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
                    end
                end

                EVAL: begin
                    count_d = edge_cnt_q;
                    if (edge_cnt_q <= target_q) begin
                        locked_d = 1'b1;
                        state_d  = DONE;
                    end else if (sel_q == SEL_LAST) begin
                        locked_d  = 1'b0;
                        ring_en_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        sel_d     = sel_q + 1'b1;
                        cyc_cnt_d = '0;
                        state_d   = SETTLE;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_cnt_q  <= '0;
            edge_cnt_q <= '0;
            target_q   <= '0;
            sel_q      <= '0;
            locked_q   <= 1'b0;
            ring_en_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            target_q   <= target_d;
            sel_q      <= sel_d;
            locked_q   <= locked_d;
            ring_en_q  <= ring_en_d;
            count_q    <= count_d;
        end
    end

    // Status outputs decode directly from the state register.
    assign busy      = (state_q == SETTLE) || (state_q == MEASURE) || (state_q == EVAL);
    assign done      = (state_q == DONE);
    assign ring_en   = ring_en_q;
    assign stage_sel = sel_q;
    assign locked    = locked_q;
    assign count     = count_q;

endmodule

// File: tb/tb_ring_osc_cal_ctrl.sv
`timescale 1ns/1ps
module tb_ring_osc_cal_ctrl;

    // Main instance: SETTLE=4, WINDOW=64 -> 69 cycles per tap
    localparam int S_A = 4;
    localparam int W_A = 64;
    localparam int TAP = S_A + W_A + 1;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] target;
    logic        ring_in;
    logic        ring_en, busy, done, locked;
    logic [2:0]  stage_sel;
    logic [15:0] count;
    logic        ring_hold;
    int          ring_ph;

    // Saturation instance: CNT_W=4, WINDOW=128
    logic        start_b;
    logic [3:0]  target_b;
    logic        ring_in_b;
    logic        ring_en_b, busy_b, done_b, locked_b;
    logic [2:0]  stage_sel_b;
    logic [3:0]  count_b;
    int          ring_ph_b;

    int checks;
    int failures;

    ring_osc_cal_ctrl #(.SEL_W(3), .CNT_W(16), .SETTLE_CYC(S_A), .WINDOW_CYC(W_A)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .target(target),
        .ring_in(ring_in), .ring_en(ring_en), .stage_sel(stage_sel), .busy(busy),
        .done(done), .locked(locked), .count(count)
    );

    ring_osc_cal_ctrl #(.SEL_W(3), .CNT_W(4), .SETTLE_CYC(4), .WINDOW_CYC(128)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .target(target_b),
        .ring_in(ring_in_b), .ring_en(ring_en_b), .stage_sel(stage_sel_b), .busy(busy_b),
        .done(done_b), .locked(locked_b), .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ring model: period 4*(stage_sel+1) clk while enabled, low when disabled,
    // or stuck high when ring_hold is set.
    always @(negedge clk) begin
        if (ring_hold) begin
            ring_in = 1'b1;
            ring_ph = 0;
        end else if (!ring_en) begin
            ring_in = 1'b0;
            ring_ph = 0;
        end else if (ring_ph >= 2 * (int'(stage_sel) + 1) - 1) begin
            ring_ph = 0;
            ring_in = ~ring_in;
        end else begin
            ring_ph = ring_ph + 1;
        end
    end

    // Fixed period-4 ring for the saturation instance.
    always @(negedge clk) begin
        if (!ring_en_b) begin
            ring_in_b = 1'b0;
            ring_ph_b = 0;
        end else if (ring_ph_b >= 1) begin
            ring_ph_b = 0;
            ring_in_b = ~ring_in_b;
        end else begin
            ring_ph_b = ring_ph_b + 1;
        end
    end

    // Pulse start for one edge (edge N); returns at #1 after edge N.
    task automatic pulse_start(input logic [15:0] tgt);
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Cycles until done is seen on the main instance, bounded by budget.
    task automatic wait_done(input int budget, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; abort = 0; target = 0; ring_hold = 0;
        start_b = 0; target_b = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ring_en !== 1'b0)   begin failures++; $display("[TB] FAIL reset_ring_en got=%b exp=0", ring_en); end
        checks++; if (stage_sel !== 3'd0) begin failures++; $display("[TB] FAIL reset_stage_sel got=%0d exp=0", stage_sel); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (locked !== 1'b0)    begin failures++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (count !== 16'd0)    begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lock_tap1;
        int cyc; bit seen;
        pulse_start(16'd9);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL lock1_busy_at_start got=%b exp=1", busy); end
        wait_done(2000, cyc, seen);
        checks++; if (!seen || cyc != 2 * TAP) begin failures++; $display("[TB] FAIL lock1_done_cycle got=%0d seen=%0b exp=%0d", cyc, seen, 2 * TAP); end
        checks++; if (locked !== 1'b1)    begin failures++; $display("[TB] FAIL lock1_locked got=%b exp=1", locked); end
        checks++; if (stage_sel !== 3'd1) begin failures++; $display("[TB] FAIL lock1_stage_sel got=%0d exp=1", stage_sel); end
        checks++; if (count < 16'd7 || count > 16'd9) begin failures++; $display("[TB] FAIL lock1_count got=%0d exp=8+-1", count); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL lock1_busy_in_done got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0)      begin failures++; $display("[TB] FAIL lock1_done_single got=%b exp=0", done); end
        checks++; if (ring_en !== 1'b1)   begin failures++; $display("[TB] FAIL lock1_ring_en got=%b exp=1", ring_en); end
    endtask

    task automatic test_sweep_all;
        int cyc; bit seen;
        pulse_start(16'd1);
        wait_done(2000, cyc, seen);
        checks++; if (!seen || cyc != 8 * TAP) begin failures++; $display("[TB] FAIL sweep_done_cycle got=%0d seen=%0b exp=%0d", cyc, seen, 8 * TAP); end
        checks++; if (locked !== 1'b0)    begin failures++; $display("[TB] FAIL sweep_locked got=%b exp=0", locked); end
        checks++; if (ring_en !== 1'b0)   begin failures++; $display("[TB] FAIL sweep_ring_en got=%b exp=0", ring_en); end
        checks++; if (stage_sel !== 3'd7) begin failures++; $display("[TB] FAIL sweep_stage_sel got=%0d exp=7", stage_sel); end
        checks++; if (count < 16'd1 || count > 16'd3) begin failures++; $display("[TB] FAIL sweep_count got=%0d exp=2+-1", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int cyc; bit seen; int early; int extra;
        early = 0; extra = 0;
        pulse_start(16'd16);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) early++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(500, cyc, seen);
        checks++; if (!seen || early != 0 || cyc + 21 != TAP) begin failures++; $display("[TB] FAIL b2b_done_cycle got=%0d seen=%0b early=%0d exp=%0d", cyc + 21, seen, early, TAP); end
        checks++; if (stage_sel !== 3'd0) begin failures++; $display("[TB] FAIL b2b_stage_sel got=%0d exp=0", stage_sel); end
        checks++; if (locked !== 1'b1)    begin failures++; $display("[TB] FAIL b2b_locked got=%b exp=1", locked); end
        checks++; if (count < 16'd15 || count > 16'd17) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=16+-1", count); end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("[TB] FAIL b2b_no_second_run got=%0d exp=0", extra); end
    endtask

    task automatic test_abort;
        int extra;
        extra = 0;
        pulse_start(16'd1);
        for (int i = 0; i < 159; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (ring_en !== 1'b0)   begin failures++; $display("[TB] FAIL abort_ring_en got=%b exp=0", ring_en); end
        checks++; if (locked !== 1'b0)    begin failures++; $display("[TB] FAIL abort_locked got=%b exp=0", locked); end
        checks++; if (stage_sel !== 3'd2) begin failures++; $display("[TB] FAIL abort_stage_sel got=%0d exp=2", stage_sel); end
        checks++; if (count < 16'd7 || count > 16'd9) begin failures++; $display("[TB] FAIL abort_count_kept got=%0d exp=8+-1", count); end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", extra); end
        abort = 1'b1; start = 1'b1; target = 16'hFFFF;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0 || ring_en !== 1'b0) begin failures++; $display("[TB] FAIL abort_start_same busy=%b ring_en=%b exp=0,0", busy, ring_en); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_start_stays_idle got=%b exp=0", busy); end
    endtask

    task automatic test_dead_ring;
        int cyc; bit seen;
        ring_hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pulse_start(16'd0);
        wait_done(2000, cyc, seen);
        checks++; if (!seen || cyc != TAP) begin failures++; $display("[TB] FAIL dead_done_cycle got=%0d seen=%0b exp=%0d", cyc, seen, TAP); end
        checks++; if (count !== 16'd0)    begin failures++; $display("[TB] FAIL dead_count got=%0d exp=0", count); end
        checks++; if (locked !== 1'b1)    begin failures++; $display("[TB] FAIL dead_locked got=%b exp=1", locked); end
        checks++; if (stage_sel !== 3'd0) begin failures++; $display("[TB] FAIL dead_stage_sel got=%0d exp=0", stage_sel); end
        @(posedge clk); #1;
        ring_hold = 1'b0;
    endtask

    task automatic test_reset_mid;
        pulse_start(16'd1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (ring_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || locked !== 1'b0 || stage_sel !== 3'd0 || count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_outputs got ring_en=%b busy=%b done=%b locked=%b sel=%0d count=%0d exp all 0", ring_en, busy, done, locked, stage_sel, count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_saturation;
        int cyc; bit seen;
        target_b = 4'd15;
        start_b  = 1'b1;
        @(posedge clk); #1;
        start_b  = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (done_b) seen = 1'b1;
        end
        checks++; if (!seen || cyc != 4 + 128 + 1) begin failures++; $display("[TB] FAIL sat_done_cycle got=%0d seen=%0b exp=133", cyc, seen); end
        checks++; if (count_b !== 4'd15)    begin failures++; $display("[TB] FAIL sat_count got=%0d exp=15", count_b); end
        checks++; if (locked_b !== 1'b1)    begin failures++; $display("[TB] FAIL sat_locked got=%b exp=1", locked_b); end
        checks++; if (stage_sel_b !== 3'd0) begin failures++; $display("[TB] FAIL sat_stage_sel got=%0d exp=0", stage_sel_b); end
        checks++; if (busy_b !== 1'b0)      begin failures++; $display("[TB] FAIL sat_busy got=%b exp=0", busy_b); end
    endtask

    initial begin
        checks = 0; failures = 0;
        ring_in = 1'b0; ring_ph = 0; ring_in_b = 1'b0; ring_ph_b = 0;
        test_reset();
        test_lock_tap1();
        test_sweep_all();
        test_back_to_back();
        test_abort();
        test_dead_ring();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
